// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Build option DMEM_ARB_FIXED_PRIO_EN is consumed by dmem_arbiter.
package dmem_arb_pkg;

  typedef enum logic {IDLE, RMW} arb_state_t;

  localparam int NUM_PORTS = 2;
  localparam int BYTE_W    = 8;

  // Byte-lane merge used to build the read-modify-write word.
  function automatic logic [BYTE_W-1:0] be_merge(input logic [BYTE_W-1:0] old_byte,
                                                 input logic [BYTE_W-1:0] new_byte,
                                                 input logic              be);
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way picker: a lone requester wins, a tie goes to the port equal to rr_ptr.
module dmem_rr_arb
  import dmem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] valid,
  input  logic                 rr_ptr,
  output logic [NUM_PORTS-1:0] grant_oh,
  output logic                 gnt_idx
);

  // NOTE: every output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    grant_oh = '0;
    gnt_idx  = (valid == 2'b11) ? rr_ptr : valid[1];
    if (|valid) grant_oh[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port word memory between two requesters; sub-word stores run as a 2-cycle RMW.
// Define DMEM_ARB_FIXED_PRIO_EN to make port 0 win every tie (no round-robin pointer).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  input  logic [NUM_PORTS*BE_W-1:0]   req_be,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  arb_state_t             state_q, state_d;
  logic [NUM_PORTS-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic [DATA_W-1:0]      rmw_data_q, rmw_data_d;
  logic [ADDR_W-1:0]      rmw_addr_q, rmw_addr_d;
  logic                   grant_q, grant_d;

  logic                   rr_ptr;
  logic [NUM_PORTS-1:0]   grant_oh;
  logic                   gnt_idx;
  logic                   sel_we;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic [BE_W-1:0]        sel_be;
  logic [DATA_W-1:0]      rmw_merged;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign rr_ptr = 1'b0;
`else
  logic rr_ptr_q;
  assign rr_ptr = rr_ptr_q;

  // An accepted port p hands priority to the other port; req_ready is one-hot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rr_ptr_q <= 1'b0;
    else if (|req_ready) rr_ptr_q <= ~req_ready[1];
  end
`endif

  dmem_rr_arb u_rr_arb (
    .valid    (req_valid),
    .rr_ptr   (rr_ptr),
    .grant_oh (grant_oh),
    .gnt_idx  (gnt_idx)
  );

  assign sel_we    = gnt_idx ? req_we[1] : req_we[0];
  assign sel_addr  = gnt_idx ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
  assign sel_wdata = gnt_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  assign sel_be    = gnt_idx ? req_be[2*BE_W-1:BE_W]        : req_be[BE_W-1:0];

  always_comb begin
    for (int b = 0; b < BE_W; b++) begin
      rmw_merged[b*BYTE_W +: BYTE_W] = be_merge(mem_rdata[b*BYTE_W +: BYTE_W],
                                                sel_wdata[b*BYTE_W +: BYTE_W], sel_be[b]);
    end
  end

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rmw_data_d  = rmw_data_q;
    rmw_addr_d  = rmw_addr_q;
    grant_d     = grant_q;
    req_ready   = '0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          mem_addr = sel_addr;
          if (!sel_we) begin
            req_ready   = grant_oh;
            rsp_valid_d = grant_oh;
            rsp_rdata_d = mem_rdata;
          end else if (&sel_be) begin
            req_ready = grant_oh;
            mem_we    = 1'b1;
            mem_wdata = sel_wdata;
          end else if (~|sel_be) begin
            req_ready = grant_oh;
          end else begin
            // Partial store: hold off ready until the merged word is written back.
            rmw_data_d = rmw_merged;
            rmw_addr_d = sel_addr;
            grant_d    = gnt_idx;
            state_d    = RMW;
          end
        end
      end
      RMW: begin
        mem_we             = 1'b1;
        mem_addr           = rmw_addr_q;
        mem_wdata          = rmw_data_q;
        req_ready[grant_q] = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset also quiets the combinational outputs, which aborts an in-flight RMW write.
    if (!rst_n) begin
      req_ready = '0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rmw_data_q  <= '0;
      rmw_addr_q  <= '0;
      grant_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rmw_data_q  <= rmw_data_d;
      rmw_addr_q  <= rmw_addr_d;
      grant_q     <= grant_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
